// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the int_ctrl vectored interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  // Channel index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Caller truncates to its own vector width, giving modulo-2^VEC_W wrap.
  function automatic logic [31:0] calc_vector(input logic [31:0] base,
                                              input logic [31:0] idx,
                                              input int          shift);
    return base + (idx << shift);
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Request/handshake bundle between int_ctrl (slave) and the sequencer/control side (master).
interface int_ctrl_if
  import int_ctrl_pkg::*;
#(
  parameter int N_IRQ = 5,
  parameter int VEC_W = 8
);
  localparam int IDX_W = idx_w(N_IRQ);

  logic [N_IRQ-1:0] irq_in;
  logic             mask_wr;
  logic [N_IRQ-1:0] mask_data;
  logic             int_en_set;
  logic             int_en_clr;
  logic [N_IRQ-1:0] int_clr;
  logic             int_ack;
  logic             eoi;

  logic             int_req;
  logic [IDX_W-1:0] irq_no;
  logic [VEC_W-1:0] vector;
  logic [N_IRQ-1:0] pending;
  logic             in_service;
  logic             int_en;

  modport master (
    output irq_in, mask_wr, mask_data, int_en_set, int_en_clr, int_clr, int_ack, eoi,
    input  int_req, irq_no, vector, pending, in_service, int_en
  );

  modport slave (
    input  irq_in, mask_wr, mask_data, int_en_set, int_en_clr, int_clr, int_ack, eoi,
    output int_req, irq_no, vector, pending, in_service, int_en
  );

endinterface

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: highest set index wins, valid when any bit is set.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter  int N_IRQ = 5,
  localparam int IDX_W = idx_w(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: pending/mask/enable, priority select, req/ack/eoi handshake.
// Define INT_CTRL_EDGE_DETECT_EN for synchronised rising-edge request capture (default: level).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int               N_IRQ     = 5,
  parameter int               VEC_W     = 8,
  parameter logic [VEC_W-1:0] VEC_BASE  = VEC_W'(0),
  parameter int               VEC_SHIFT = 1
) (
  input logic       clk,
  input logic       rst,
  int_ctrl_if.slave bus
);

  localparam int IDX_W = idx_w(N_IRQ);

  state_t           state;
  logic [N_IRQ-1:0] mask;
  logic             saved_en;
  logic [N_IRQ-1:0] set_v;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] eligible;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [VEC_W-1:0] win_vec;
  logic             ack_fire;
  logic             eoi_fire;

`ifdef INT_CTRL_EDGE_DETECT_EN
  logic [N_IRQ-1:0] sync1, sync2, sync3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= bus.irq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign set_v = sync2 & ~sync3;
`else
  assign set_v = bus.irq_in;
`endif

  assign ack_fire = (state == REQ) && bus.int_ack;
  assign eoi_fire = (state == SERVICE) && bus.eoi;
  assign eligible = bus.pending & mask & {N_IRQ{bus.int_en}};
  assign win_vec  = VEC_W'(calc_vector(32'(VEC_BASE), 32'(win_idx), VEC_SHIFT));

  always_comb begin
    ack_clr = '0;
    if (ack_fire) ack_clr[bus.irq_no] = 1'b1;
  end

  int_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req  (eligible),
    .valid(win_valid),
    .idx  (win_idx)
  );

  // Set beats any clear in the same cycle so a request arriving at clear time is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pending <= '0;
      mask        <= '1;
    end else begin
      bus.pending <= set_v | (bus.pending & ~(bus.int_clr | ack_clr));
      if (bus.mask_wr) mask <= bus.mask_data;
    end
  end

  // Ack forces the enable off; elsewhere an explicit clr/set beats the eoi restore.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.int_en <= 1'b1;
      saved_en   <= 1'b0;
    end else if (ack_fire) begin
      bus.int_en <= 1'b0;
      saved_en   <= bus.int_en;
    end else if (bus.int_en_clr) begin
      bus.int_en <= 1'b0;
    end else if (bus.int_en_set) begin
      bus.int_en <= 1'b1;
    end else if (eoi_fire) begin
      bus.int_en <= saved_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bus.int_req    <= 1'b0;
      bus.irq_no     <= '0;
      bus.vector     <= VEC_BASE;
      bus.in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state       <= REQ;
            bus.int_req <= 1'b1;
            bus.irq_no  <= win_idx;
            bus.vector  <= win_vec;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state          <= SERVICE;
            bus.int_req    <= 1'b0;
            bus.in_service <= 1'b1;
          end else if (!win_valid) begin
            state       <= IDLE;
            bus.int_req <= 1'b0;
          end else begin
            bus.irq_no <= win_idx;
            bus.vector <= win_vec;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state          <= IDLE;
            bus.in_service <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          bus.int_req    <= 1'b0;
          bus.in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed table-driven bench for int_ctrl (default parameters, N_IRQ=5, VEC_W=8).
module tb_int_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  int_ctrl_if #(.N_IRQ(5), .VEC_W(8)) bus ();

  int_ctrl #(.N_IRQ(5), .VEC_W(8), .VEC_BASE(8'h00), .VEC_SHIFT(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [4:0] irq;
    logic       mwr;
    logic [4:0] mdata;
    logic       es;
    logic       ec;
    logic [4:0] clr;
    logic       ack;
    logic       eoi;
    logic       req;
    logic [2:0] no;
    logic [7:0] vec;
    logic [4:0] pend;
    logic       svc;
    logic       en;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(logic [4:0] irq, logic mwr, logic [4:0] mdata, logic es,
                              logic ec, logic [4:0] clr, logic ack, logic eoi,
                              logic req, logic [2:0] no, logic [7:0] vec,
                              logic [4:0] pend, logic svc, logic en);
    row_t r;
    r.irq = irq; r.mwr = mwr; r.mdata = mdata; r.es = es; r.ec = ec;
    r.clr = clr; r.ack = ack; r.eoi = eoi;
    r.req = req; r.no = no; r.vec = vec; r.pend = pend; r.svc = svc; r.en = en;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input row_t r);
    check({tag, " int_req"},    32'(bus.int_req),    32'(r.req));
    check({tag, " irq_no"},     32'(bus.irq_no),     32'(r.no));
    check({tag, " vector"},     32'(bus.vector),     32'(r.vec));
    check({tag, " pending"},    32'(bus.pending),    32'(r.pend));
    check({tag, " in_service"}, 32'(bus.in_service), 32'(r.svc));
    check({tag, " int_en"},     32'(bus.int_en),     32'(r.en));
  endtask

  task automatic drive(input row_t r);
    bus.irq_in     = r.irq;
    bus.mask_wr    = r.mwr;
    bus.mask_data  = r.mdata;
    bus.int_en_set = r.es;
    bus.int_en_clr = r.ec;
    bus.int_clr    = r.clr;
    bus.int_ack    = r.ack;
    bus.eoi        = r.eoi;
  endtask

  task automatic apply(input row_t r, input int idx);
    @(negedge clk);
    drive(r);
    @(posedge clk);
    #1;
    check_outs($sformatf("row%0d", idx), r);
  endtask

  row_t idle_r;
  row_t rst_r;

  initial begin
    idle_r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
    rst_r  = idle_r;
    drive(idle_r);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", rst_r);
    @(negedge clk);
    rst = 1'b1;

`ifdef INT_CTRL_EDGE_DETECT_EN
    // Held-high line: one pending set three edges after the rise, none after ack.
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.irq_in  = 5'b00001;
      bus.int_ack = (c == 5);
      @(posedge clk);
      #1;
      check($sformatf("edge c%0d pending", c), 32'(bus.pending),
            (c == 3 || c == 4) ? 32'd1 : 32'd0);
      if (c == 4) check("edge int_req", 32'(bus.int_req), 32'd1);
      if (c == 5) check("edge in_service", 32'(bus.in_service), 32'd1);
    end
    @(negedge clk);
    bus.irq_in  = 5'b00000;
    bus.int_ack = 1'b0;
    bus.eoi     = 1'b1;
    @(posedge clk);
    #1;
    check("edge eoi pending", 32'(bus.pending), 32'd0);
    check("edge eoi in_service", 32'(bus.in_service), 32'd0);
    @(negedge clk);
    bus.eoi = 1'b0;
    @(posedge clk);
    #1;
    check("edge no rerequest", 32'(bus.int_req), 32'd0);
`else
    //            irq       mwr mdata    es ec clr       ack eoi  req no vec    pend      svc en
    tbl.push_back(mk(5'b00100, 0, 0,        0, 0, 0,        0, 0,   0, 0, 8'h00, 5'b00100, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   1, 2, 8'h04, 5'b00100, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 5'b00100, 0, 0,   1, 2, 8'h04, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   0, 2, 8'h04, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b10010, 0, 0,        0, 0, 0,        0, 0,   0, 2, 8'h04, 5'b10010, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   1, 4, 8'h08, 5'b10010, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        1, 0,   0, 4, 8'h08, 5'b00010, 1, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   0, 4, 8'h08, 5'b00010, 1, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 1,   0, 4, 8'h08, 5'b00010, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   1, 1, 8'h02, 5'b00010, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        1, 0,   0, 1, 8'h02, 5'b00000, 1, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 1,   0, 1, 8'h02, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b10000, 0, 0,        0, 0, 0,        0, 0,   0, 1, 8'h02, 5'b10000, 0, 1));
    tbl.push_back(mk(5'b00000, 1, 5'b01111, 0, 0, 0,        0, 0,   1, 4, 8'h08, 5'b10000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   0, 4, 8'h08, 5'b10000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   0, 4, 8'h08, 5'b10000, 0, 1));
    tbl.push_back(mk(5'b00000, 1, 5'b11111, 0, 0, 0,        0, 0,   0, 4, 8'h08, 5'b10000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   1, 4, 8'h08, 5'b10000, 0, 1));
    tbl.push_back(mk(5'b01000, 0, 0,        0, 0, 5'b11000, 0, 0,   1, 4, 8'h08, 5'b01000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        1, 1, 0,        0, 0,   1, 3, 8'h06, 5'b01000, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   0, 3, 8'h06, 5'b01000, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        1, 0, 0,        0, 0,   0, 3, 8'h06, 5'b01000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   1, 3, 8'h06, 5'b01000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        1, 0,   0, 3, 8'h06, 5'b00000, 1, 0));
    tbl.push_back(mk(5'b00001, 0, 0,        0, 0, 0,        1, 0,   0, 3, 8'h06, 5'b00001, 1, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 1, 0,        0, 1,   0, 3, 8'h06, 5'b00001, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   0, 3, 8'h06, 5'b00001, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 1,   0, 3, 8'h06, 5'b00001, 0, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        1, 0, 0,        0, 0,   0, 3, 8'h06, 5'b00001, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   1, 0, 8'h00, 5'b00001, 0, 1));
    tbl.push_back(mk(5'b00001, 0, 0,        0, 0, 0,        1, 0,   0, 0, 8'h00, 5'b00001, 1, 0));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 1,   0, 0, 8'h00, 5'b00001, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 5'b00001, 0, 0,   1, 0, 8'h00, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   0, 0, 8'h00, 5'b00000, 0, 1));
    tbl.push_back(mk(5'b00100, 0, 0,        0, 0, 0,        0, 0,   0, 0, 8'h00, 5'b00100, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        0, 0,   1, 2, 8'h04, 5'b00100, 0, 1));
    tbl.push_back(mk(5'b00000, 0, 0,        0, 0, 0,        1, 0,   0, 2, 8'h04, 5'b00000, 1, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset in the middle of SERVICE, sampled between edges.
    @(negedge clk);
    drive(idle_r);
    #2;
    rst = 1'b0;
    #1;
    check_outs("midreset", rst_r);
    @(negedge clk);
    rst = 1'b1;

    // Ack without a pending request must not disturb anything.
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1), 100);
    apply(idle_r, 101);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
